// File: rtl/sparse_mask_match_scheduler_if.sv
// rtl/sparse_mask_match_scheduler_if.sv - mask-pair input and match-beat output handshake bundle
interface sparse_mask_match_scheduler_if #(
  parameter int BITMASK_LENGTH = 16,
  parameter int MAX_NUM_OUTPUT = 2,
  parameter int INDEX_BITWIDTH = 5
);
  localparam int COUNT_BITWIDTH = $clog2(MAX_NUM_OUTPUT) + 1;

  logic                                     ivalid;
  logic                                     oready;
  logic [BITMASK_LENGTH-1:0]                bitmaskW;
  logic [BITMASK_LENGTH-1:0]                bitmaskA;
  logic                                     ovalid;
  logic                                     iready;
  logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] matchIndex;
  logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] offsetW;
  logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] offsetA;
  logic [COUNT_BITWIDTH-1:0]                matchCount;
  logic                                     lastBeat;

  // Producer/consumer side: drives mask pairs in and accepts beats out
  modport master (
    output ivalid, bitmaskW, bitmaskA, iready,
    input  oready, ovalid, matchIndex, offsetW, offsetA, matchCount, lastBeat
  );

  // Scheduler side
  modport slave (
    input  ivalid, bitmaskW, bitmaskA, iready,
    output oready, ovalid, matchIndex, offsetW, offsetA, matchCount, lastBeat
  );
endinterface

// File: rtl/sparse_mask_match_scheduler.sv
// rtl/sparse_mask_match_scheduler.sv - walks W&A mutual nonzeros, emitting up to MAX_NUM_OUTPUT matches per beat
module sparse_mask_match_scheduler #(
  parameter int BITMASK_LENGTH = 16,
  parameter int MAX_NUM_OUTPUT = 2,
  parameter int INDEX_BITWIDTH = 5
) (
  input logic clk,
  input logic rst,
  sparse_mask_match_scheduler_if.slave bus
);
  localparam int COUNT_BITWIDTH = $clog2(MAX_NUM_OUTPUT) + 1;
  localparam int LANE_BITS      = MAX_NUM_OUTPUT * INDEX_BITWIDTH;

  typedef enum logic {IDLE, SCAN} state_e;

  state_e                    state_q, state_d;
  logic [BITMASK_LENGTH-1:0] w_q, w_d, a_q, a_d;
  logic [BITMASK_LENGTH-1:0] rem_q, rem_d, rem_adv;
  logic                      ovalid_q, ovalid_d;
  logic                      oready_q, oready_d;
  logic                      last_q, last_d;
  logic [LANE_BITS-1:0]      idx_q, idx_d, offw_q, offw_d, offa_q, offa_d;
  logic [COUNT_BITWIDTH-1:0] cnt_q, cnt_d;

  assign bus.oready     = oready_q;
  assign bus.ovalid     = ovalid_q;
  assign bus.matchIndex = idx_q;
  assign bus.offsetW    = offw_q;
  assign bus.offsetA    = offa_q;
  assign bus.matchCount = cnt_q;
  assign bus.lastBeat   = last_q;

  // Remaining mask once the beat currently on the bus has been consumed
  always_comb begin : advance_remaining
    int taken;
    taken   = 0;
    rem_adv = rem_q;
    for (int k = 0; k < BITMASK_LENGTH; k++) begin
      if (rem_q[k] && taken < MAX_NUM_OUTPUT) begin
        rem_adv[k] = 1'b0;
        taken++;
      end
    end
  end

  // Next FSM state, captured masks and remaining matches
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    a_d     = a_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.ivalid) begin
          w_d     = bus.bitmaskW;
          a_d     = bus.bitmaskA;
          rem_d   = bus.bitmaskW & bus.bitmaskA;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.iready) begin
          rem_d = rem_adv;
          if (last_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next beat contents, built from next-cycle state so every output is a flop
  always_comb begin : next_outputs
    int lane;
    int total;
    int pw;
    int pa;
    lane     = 0;
    total    = 0;
    pw       = 0;
    pa       = 0;
    ovalid_d = 1'b0;
    oready_d = 1'b1;
    last_d   = 1'b0;
    cnt_d    = '0;
    idx_d    = '0;
    offw_d   = '0;
    offa_d   = '0;
    if (state_d == SCAN) begin
      ovalid_d = 1'b1;
      oready_d = 1'b0;
      for (int k = 0; k < BITMASK_LENGTH; k++) begin
        if (rem_d[k]) begin
          total++;
          if (lane < MAX_NUM_OUTPUT) begin
            idx_d[lane*INDEX_BITWIDTH +: INDEX_BITWIDTH]  = INDEX_BITWIDTH'(k);
            offw_d[lane*INDEX_BITWIDTH +: INDEX_BITWIDTH] = INDEX_BITWIDTH'(pw);
            offa_d[lane*INDEX_BITWIDTH +: INDEX_BITWIDTH] = INDEX_BITWIDTH'(pa);
            lane++;
          end
        end
        if (w_d[k]) pw++;
        if (a_d[k]) pa++;
      end
      cnt_d  = COUNT_BITWIDTH'(lane);
      last_d = (total <= MAX_NUM_OUTPUT);
    end
  end

  // FSM and registered outputs; reset drops any in-flight pair immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      w_q      <= '0;
      a_q      <= '0;
      rem_q    <= '0;
      ovalid_q <= 1'b0;
      oready_q <= 1'b1;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      offw_q   <= '0;
      offa_q   <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      a_q      <= a_d;
      rem_q    <= rem_d;
      ovalid_q <= ovalid_d;
      oready_q <= oready_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      offw_q   <= offw_d;
      offa_q   <= offa_d;
    end
  end
endmodule
